// File: rtl/dpram64_pkg.sv
// ---------------------------------------------------------------------------
// dpram64_pkg
//   Shared definitions for the 64 x 64-bit dual-port RAM (dual_port_ram_64b)
//   and its per-port output stage (dpram64_port).
//
//   Contents:
//     DEF_DATA_W / DEF_ADDR_W : default word and address widths
//     DEPTH                   : default number of words (2**DEF_ADDR_W)
//     RW_READ .. RW_WR_AB     : encodings of the shared 2-bit mode select rw
//     rw_dec_t / decode_rw    : per-port write enables decoded from rw
// ---------------------------------------------------------------------------
package dpram64_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 6;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  // rw[0] is the port A write enable, rw[1] the port B write enable.
  localparam logic [1:0] RW_READ  = 2'b00;  // both ports read
  localparam logic [1:0] RW_WR_A  = 2'b01;  // A writes, B reads
  localparam logic [1:0] RW_WR_B  = 2'b10;  // B writes, A reads
  localparam logic [1:0] RW_WR_AB = 2'b11;  // both ports write

  typedef struct packed {
    logic we_a;
    logic we_b;
  } rw_dec_t;

  function automatic rw_dec_t decode_rw(input logic [1:0] rw);
    rw_dec_t dec;
    dec = '0;
    case (rw)
      RW_READ:  dec = '{we_a: 1'b0, we_b: 1'b0};
      RW_WR_A:  dec = '{we_a: 1'b1, we_b: 1'b0};
      RW_WR_B:  dec = '{we_a: 1'b0, we_b: 1'b1};
      RW_WR_AB: dec = '{we_a: 1'b1, we_b: 1'b1};
      default:  dec = '0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/dpram64_port.sv
// ---------------------------------------------------------------------------
// dpram64_port
//   Registered read-data stage for one port of dual_port_ram_64b.
//   On every rising edge the output register either loads the word read
//   from the array (reading port) or, for a writing port, holds its value
//   or takes the port's own write data when WRITE_THROUGH is set.
//   rst_n clears the register asynchronously and keeps it at zero while low.
//
//   Ports:
//     clk     : clock
//     rst_n   : asynchronous active-low reset
//     we      : this port writes this cycle
//     din     : this port's write data
//     rd_data : array contents at this port's address (pre-edge, i.e. old data)
//     dout    : registered read data
// ---------------------------------------------------------------------------
module dpram64_port
  import dpram64_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter bit WRITE_THROUGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  always_comb begin
    dout_d = dout_q;
    if (we) begin
      // A writing port only sees its own data in the write-through build.
      dout_d = WRITE_THROUGH ? din : dout_q;
    end else begin
      dout_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/dual_port_ram_64b.sv
// ---------------------------------------------------------------------------
// dual_port_ram_64b
//   64 x 64-bit dual-port synchronous RAM, one clock domain. Both ports can
//   read and either or both can write every cycle; read data is registered
//   (one cycle latency). Cross-port accesses to the same address are
//   read-first. When both ports write the same address, port A wins.
//   Memory contents are not touched by reset; only the dout registers are
//   cleared, and writes are suppressed while rst_n is low.
//
//   Build option: define DPRAM64_WRITE_THROUGH_EN to make a writing port
//   load its own din into its dout (write-first on its own port). Without
//   it, a writing port's dout holds its previous value.
//
//   Ports:
//     clk            : clock, rising edge active
//     rst_n          : asynchronous active-low reset (clears dout_a/dout_b)
//     rw[1:0]        : mode; rw[0] = port A write, rw[1] = port B write
//     addr_a, addr_b : word addresses (full 0..2**ADDR_W-1 range)
//     din_a, din_b   : write data
//     dout_a, dout_b : registered read data
// ---------------------------------------------------------------------------
module dual_port_ram_64b
  import dpram64_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rw,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int N_PORTS   = 2;

`ifdef DPRAM64_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  rw_dec_t rw_dec;
  logic    same_addr;
  logic    we_a;
  logic    we_b;

  assign rw_dec    = decode_rw(rw);
  assign same_addr = (addr_a == addr_b);
  assign we_a      = rw_dec.we_a;
  // Port B's write is dropped when it collides with a port A write.
  assign we_b      = rw_dec.we_b && !(rw_dec.we_a && same_addr);

  // Array write. rst_n is sampled here rather than used as a reset so the
  // contents survive reset; an edge seen while rst_n is low writes nothing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (we_a) begin
        mem[addr_a] <= din_a;
      end
      if (we_b) begin
        mem[addr_b] <= din_b;
      end
    end
  end

  // Per-port views so both output stages come from one generate loop.
  logic [N_PORTS-1:0] port_we;
  logic [ADDR_W-1:0]  port_addr [N_PORTS];
  logic [DATA_W-1:0]  port_din  [N_PORTS];
  logic [DATA_W-1:0]  port_rd   [N_PORTS];
  logic [DATA_W-1:0]  port_dout [N_PORTS];

  // The per-port enable is the raw rw bit: a port B write that lost a
  // collision is still a writing port as far as its own dout is concerned.
  assign port_we[0]   = rw_dec.we_a;
  assign port_we[1]   = rw_dec.we_b;
  assign port_addr[0] = addr_a;
  assign port_addr[1] = addr_b;
  assign port_din[0]  = din_a;
  assign port_din[1]  = din_b;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      // Old contents: the array update lands on the same edge that the
      // port register samples this value, which gives read-first behaviour.
      assign port_rd[gi] = mem[port_addr[gi]];

      dpram64_port #(
        .DATA_W        (DATA_W),
        .WRITE_THROUGH (WRITE_THROUGH)
      ) u_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (port_we[gi]),
        .din     (port_din[gi]),
        .rd_data (port_rd[gi]),
        .dout    (port_dout[gi])
      );
    end
  endgenerate

  assign dout_a = port_dout[0];
  assign dout_b = port_dout[1];

endmodule

// File: tb/tb_dual_port_ram_64b.sv
module tb_dual_port_ram_64b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rw;
  logic [5:0]  addr_a, addr_b;
  logic [63:0] din_a, din_b;
  logic [63:0] dout_a, dout_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dual_port_ram_64b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rw     (rw),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .din_a  (din_a),
    .din_b  (din_b),
    .dout_a (dout_a),
    .dout_b (dout_b)
  );

  // Reference model of the RAM behaviour.
  logic [63:0] m_mem [64];
  bit          m_val [64];
  logic [63:0] m_a, m_b;
  bit          k_a, k_b;

  typedef struct {
    string       tag;
    logic [63:0] exp_a;
    bit          known_a;
    logic [63:0] exp_b;
    bit          known_b;
  } sb_t;

  sb_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict, push, clock, pop and compare.
  task automatic step(input string tag, input bit rst_low, input logic [1:0] r,
                      input logic [5:0] aa, input logic [5:0] ab,
                      input logic [63:0] da, input logic [63:0] db);
    sb_t         e;
    sb_t         got;
    logic [63:0] ra, rb;
    bit          va, vb;
    rw = r; addr_a = aa; addr_b = ab; din_a = da; din_b = db;
    if (rst_low) rst_n = 1'b0;
    if (rst_low) begin
      m_a = '0; k_a = 1; m_b = '0; k_b = 1;
    end else begin
      ra = m_mem[aa]; va = m_val[aa];
      rb = m_mem[ab]; vb = m_val[ab];
      if (r[0]) begin
`ifdef DPRAM64_WRITE_THROUGH_EN
        m_a = da; k_a = 1;
`endif
      end else begin
        m_a = ra; k_a = va;
      end
      if (r[1]) begin
`ifdef DPRAM64_WRITE_THROUGH_EN
        m_b = db; k_b = 1;
`endif
      end else begin
        m_b = rb; k_b = vb;
      end
      // B first so an A write to the same address overrides it.
      if (r[1]) begin m_mem[ab] = db; m_val[ab] = 1; end
      if (r[0]) begin m_mem[aa] = da; m_val[aa] = 1; end
    end
    e.tag = tag; e.exp_a = m_a; e.known_a = k_a; e.exp_b = m_b; e.known_b = k_b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (got.known_a) check({got.tag, "/dout_a"}, dout_a, got.exp_a);
    if (got.known_b) check({got.tag, "/dout_b"}, dout_b, got.exp_b);
    $display("step %-10s rst_low=%0d rw=%b a=%0d b=%0d dout_a=%h dout_b=%h",
             tag, rst_low, r, aa, ab, dout_a, dout_b);
    if (rst_low) rst_n = 1'b1;
  endtask

  // Reset pulse strictly between edges; dout must clear immediately.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "/dout_a"}, dout_a, 64'h0);
    check({tag, "/dout_b"}, dout_b, 64'h0);
    rst_n = 1'b1;
    m_a = '0; k_a = 1; m_b = '0; k_b = 1;
    $display("reset pulse %s dout_a=%h dout_b=%h", tag, dout_a, dout_b);
  endtask

  localparam logic [63:0] P5 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;

  initial begin
    for (int i = 0; i < 64; i++) m_val[i] = 0;
    rst_n = 1'b0; rw = 2'b00; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    m_a = '0; k_a = 1; m_b = '0; k_b = 1;
    #1;
    check("reset/dout_a", dout_a, 64'h0);
    check("reset/dout_b", dout_b, 64'h0);
    #2;
    rst_n = 1'b1;

    // Basic write then read.
    step("wr_a0",   0, 2'b01, 6'd0, 6'd0, P5, 64'h0);
    step("wr_b1",   0, 2'b10, 6'd0, 6'd1, 64'h0, PA);
    step("rd_01",   0, 2'b00, 6'd0, 6'd1, 64'h0, 64'h0);
    check("basic/lit_a", dout_a, P5);
    check("basic/lit_b", dout_b, PA);

    // Asynchronous reset pulse; contents retained.
    #2;
    pulse_reset("rst_pulse");
    step("rd_post",  0, 2'b00, 6'd0, 6'd1, 64'h0, 64'h0);
    check("post_rst/lit_a", dout_a, P5);
    check("post_rst/lit_b", dout_b, PA);

    // Write/write collision: A wins.
    step("ww_coll",  0, 2'b11, 6'd5, 6'd5, 64'h1, 64'h2);
    step("rd_5",     0, 2'b00, 6'd5, 6'd5, 64'h0, 64'h0);
    check("coll/lit", dout_b, 64'h1);

    // Read-first across ports, then hold / write-through on port A.
    step("wr_7",     0, 2'b01, 6'd7, 6'd0, 64'h10, 64'h0);
    step("rd_5_7",   0, 2'b00, 6'd5, 6'd7, 64'h0, 64'h0);
    step("rf_7",     0, 2'b01, 6'd7, 6'd7, 64'h20, 64'h0);
    check("rf/lit_old", dout_b, 64'h10);
    step("rf_7_next",0, 2'b00, 6'd5, 6'd7, 64'h0, 64'h0);
    check("rf/lit_new", dout_b, 64'h20);
    step("hold_a",   0, 2'b01, 6'd9, 6'd7, 64'hDEAD, 64'h0);
`ifdef DPRAM64_WRITE_THROUGH_EN
    check("wt/lit", dout_a, 64'hDEAD);
`else
    check("hold/lit", dout_a, 64'h1);
`endif
    step("rd_9",     0, 2'b00, 6'd9, 6'd9, 64'h0, 64'h0);

    // Address extremes.
    step("wr_ext",   0, 2'b11, 6'd0, 6'd63, 64'hA0, 64'hA63);
    step("rd_ext",   0, 2'b00, 6'd0, 6'd63, 64'h0, 64'h0);
    step("rd_ext_x", 0, 2'b00, 6'd63, 6'd0, 64'h0, 64'h0);
    check("ext/lit_a63", dout_a, 64'hA63);
    check("ext/lit_b0",  dout_b, 64'hA0);

    // B writes while A reads the same address: A sees old data.
    step("rf_b63",   0, 2'b10, 6'd63, 6'd63, 64'h0, 64'hBEEF);
    step("rd_63",    0, 2'b00, 6'd63, 6'd63, 64'h0, 64'h0);

    // Reset held across an edge: that write is lost.
    step("wr_20",    0, 2'b01, 6'd20, 6'd0, 64'h1234, 64'h0);
    step("rst_wr20", 1, 2'b01, 6'd20, 6'd0, 64'h77, 64'h0);
    step("rd_20",    0, 2'b00, 6'd20, 6'd20, 64'h0, 64'h0);
    check("rst_wr/lit", dout_a, 64'h1234);

    // Mixed random traffic over a small address window.
    for (int i = 0; i < 24; i++) begin
      step("rand", 0, 2'($urandom_range(3, 0)), 6'($urandom_range(7, 0)),
           6'($urandom_range(7, 0)), {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
